// File: rtl/lfsr_tercnt_gen.sv
// lfsr_tercnt_gen
// XNOR-feedback LFSR with a programmable tap mask that raises a one-cycle
// terminal pulse when the count reaches a programmed match value. It runs in
// free-run, auto-reload or one-shot mode, keeps a saturating count of
// terminal hits, and steps out of the LFSR lock-up state if it ever lands there.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | count held, waiting for start (entered on reset and on load)
// RUN    | count advances on every cycle with cen=1
// DONE   | one-shot has reached its terminal value, count held until start

module lfsr_tercnt_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'b01100011,
    parameter int               HIT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] match,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             cen,
    output logic [WIDTH-1:0] count,
    output logic             tercnt,
    output logic             busy,
    output logic             done,
    output logic [HIT_W-1:0] hit_cnt,
    output logic             lockup_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] MODE_RELOAD  = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] seed_r;
    logic [WIDTH-1:0] match_r;
    logic [1:0]       mode_r;

    logic             feedback;
    logic [WIDTH-1:0] lfsr_nxt;
    logic             lock_hit;
    logic [WIDTH-1:0] step_val;
    logic             reload;
    logic [WIDTH-1:0] adv_val;
    logic             adv;
    logic             term;

    // Next-count selection: LFSR step with lock-up escape, or reload to seed.
    // The reload path bypasses the escape so a seed equal to match gives
    // a period-1 sequence.
    always_comb begin
        feedback = ~^(count & POLY);
        lfsr_nxt = {feedback, count[WIDTH-1:1]};
        lock_hit = (lfsr_nxt == count);
        step_val = lock_hit ? ~count : lfsr_nxt;
        reload   = (mode_r == MODE_RELOAD) && (count == match_r);
        adv_val  = reload ? seed_r : step_val;
        adv      = (state == S_RUN) && cen;
        term     = adv && (adv_val == match_r);
    end

    // Configuration capture, run-state sequencing and the count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= '0;
            seed_r  <= '0;
            match_r <= '0;
            mode_r  <= '0;
            tercnt  <= 1'b0;
        end else if (load) begin
            state   <= S_IDLE;
            count   <= seed;
            seed_r  <= seed;
            match_r <= match;
            mode_r  <= mode;
            tercnt  <= 1'b0;
        end else begin
            tercnt <= term;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (adv) begin
                        count <= adv_val;
                        if (term && (mode_r == MODE_ONESHOT)) begin
                            state <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Saturating terminal-hit counter and sticky lock-up flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt    <= '0;
            lockup_err <= 1'b0;
        end else if (load) begin
            hit_cnt    <= '0;
            lockup_err <= 1'b0;
        end else begin
            if (term && !(&hit_cnt)) begin
                hit_cnt <= hit_cnt + HIT_W'(1);
            end
            if (adv && !reload && lock_hit) begin
                lockup_err <= 1'b1;
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
